mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, read cycles from address drive to mem_read_data valid (legal range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_req  input  1  instruction-fetch request (read only).
REQ-007 SHALL have port i_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port i_ack  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port i_rdata  output  DATA_W  fetched word.
REQ-010 SHALL have port d_req  input  1  data-access request.
REQ-011 SHALL have port d_we  input  1  data access is a write (1) or read (0).
REQ-012 SHALL have port d_addr  input  ADDR_W  data address.
REQ-013 SHALL have port d_wdata  input  DATA_W  store data.
REQ-014 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-015 SHALL have port d_rdata  output  DATA_W  loaded word.
REQ-016 SHALL have port mem_address  output  ADDR_W  shared memory address.
REQ-017 SHALL have port mem_write  output  1  shared memory write strobe.
REQ-018 SHALL have port mem_write_data  output  DATA_W  shared memory write data.
REQ-019 SHALL have port mem_read_data  input  DATA_W  shared memory read data.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on any sampled req; ACCESS->DONE when access count expires; DONE->IDLE unconditionally.
REQ-021 SHALL, in IDLE, grant a single requester: if only one req is high, grant it; if both, grant the port not granted last (round-robin); first contention after reset goes to the instruction port.
REQ-022 SHALL register granted port, address, we and wdata on IDLE->ACCESS; requesters hold req/addr/we/wdata stable until ack.
REQ-023 SHALL drive mem_address and mem_write_data from the registered values during ACCESS and DONE, and drive 0 on both in IDLE.
REQ-024 SHALL keep read accesses in ACCESS for exactly MEM_LATENCY cycles and sample mem_read_data on the edge ending the last ACCESS cycle.
REQ-025 SHALL keep write accesses in ACCESS for exactly 1 cycle with mem_write=1 only in that cycle; mem_write SHALL be 0 in every other cycle.
REQ-026 SHALL assert the granted port's ack for exactly the one DONE cycle; the other ack stays 0; i_ack and d_ack never both 1.
REQ-027 SHALL give request-to-ack latency of MEM_LATENCY+1 cycles for reads and 2 cycles for writes, measured from the IDLE cycle the req was sampled.
REQ-028 SHALL hold i_rdata/d_rdata registered, updated only at a read completion on that port, stable otherwise.
REQ-029 SHALL ignore req changes outside IDLE; a req still high in the IDLE cycle after DONE is a new back-to-back request.
REQ-030 SHALL, under continuous contention, alternate grants I,D,I,D...; neither port waits more than one foreign access.
REQ-031 SHALL use an access counter of width $clog2(MEM_LATENCY+1), loaded on IDLE->ACCESS, decremented each ACCESS cycle, never wrapping.

Reset
REQ-032 SHALL, on rst=1 at any edge (including mid-ACCESS), go to IDLE, clear counter, mem_write=0, mem_address=0, mem_write_data=0, i_ack=d_ack=0, i_rdata=d_rdata=0, round-robin pointer = instruction-first.
REQ-033 SHALL abandon any in-flight access on reset with no ack ever issued for it.

Structure
REQ-034 SHALL place the state enum, port-id constants (PORT_I=0, PORT_D=1) and default ADDR_W/DATA_W in shared package mem_pkg.
REQ-035 SHALL factor the two-way round-robin decision into sub-module rr_arb2 (req[1:0], last, grant[1:0]), purely combinational plus pointer register in mem_arbiter.

Verification
REQ-036 Single fetch, MEM_LATENCY=1: i_req=1, i_addr=0x0000_0040, memory returns 0x2008_0005 -> mem_address=0x40 next cycle, i_ack pulse 2 cycles after req, i_rdata=0x2008_0005.
REQ-037 Single store: d_req=1, d_we=1, d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF -> mem_write=1 for exactly one cycle with those values, d_ack 2 cycles after req, i_ack stays 0.
REQ-038 Contention: i_req and d_req rise same cycle after reset, both held -> instruction granted first, data second, then instruction; acks never overlap.
REQ-039 MEM_LATENCY=3 load: d_req, d_we=0, d_addr=0x200 -> ACCESS lasts 3 cycles, d_ack at cycle 4, d_rdata equals memory word at 0x200.
REQ-040 Reset mid-access: rst=1 during second ACCESS cycle of a 3-cycle read -> next cycle IDLE, mem_address=0, no d_ack; fresh request after rst=0 completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_e      : arbiter sequencing states
//   PORT_I / PORT_D  : requester ids (also bit positions in rr_arb2 vectors)
//   MEM_ADDR_W/DATA_W: default bus widths
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant decision (purely combinational).
//   req[1:0]   : request vector, bit PORT_I = fetch, bit PORT_D = data
//   last       : port id granted most recently
//   grant[1:0] : one-hot grant (all zero when no request)
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: favour the port that did not win last time.
            2'b11:   grant = (last == PORT_I) ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared single-ported memory between an instruction-fetch
// port (read only) and a data port (read/write).
//   clk, rst                          : clock, synchronous active-high reset
//   i_req/i_addr -> i_ack/i_rdata     : fetch request, completion pulse, word
//   d_req/d_we/d_addr/d_wdata
//                -> d_ack/d_rdata     : data request, completion pulse, word
//   mem_address/mem_write/
//   mem_write_data <- mem_read_data   : shared memory bus
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = MEM_ADDR_W,
    parameter int unsigned DATA_W      = MEM_DATA_W,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]        grant;

    rr_arb2 u_rr (
        .req   ({d_req, i_req}),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        last_d    = last_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    state_d = ACCESS;
                    if (grant[PORT_D]) begin
                        port_d  = PORT_D;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        cnt_d   = d_we ? CNT_W'(1) : CNT_W'(MEM_LATENCY);
                    end else begin
                        port_d  = PORT_I;
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        cnt_d   = CNT_W'(MEM_LATENCY);
                    end
                    last_d = port_d;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                // Count of 1 marks the final ACCESS cycle; read data is
                // captured on the edge that ends it so it is valid in DONE.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (port_q == PORT_D) begin
                            d_rdata_d = mem_read_data;
                        end else begin
                            i_rdata_d = mem_read_data;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            port_q    <= PORT_I;
            last_q    <= PORT_D;  // first contention goes to fetch
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_address    = (state_q == IDLE) ? '0 : addr_q;
    assign mem_write_data = (state_q == IDLE) ? '0 : wdata_q;
    assign mem_write      = (state_q == ACCESS) && we_q;
    assign i_ack          = (state_q == DONE) && (port_q == PORT_I);
    assign d_ack          = (state_q == DONE) && (port_q == PORT_D);
    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 3-cycle memory.
module tb_mem_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_write;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] seed_word(input int unsigned idx);
        return (idx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: data is only presented once the same address has been
    // driven for LAT cycles (counting the current one); before that a poison
    // value is returned.
    logic [31:0] mem [0:255];
    logic [31:0] refm [0:255];
    logic [31:0] trk_addr = '0;
    int          run = 0;
    bit          mem_loaded = 0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
            mem[16] <= 32'h2008_0005;
            mem_loaded <= 1;
        end else if (mem_write) begin
            mem[mem_address[9:2]] <= mem_write_data;
        end
        if (mem_address == trk_addr) run <= run + 1;
        else begin
            trk_addr <= mem_address;
            run      <= 1;
        end
    end

    function automatic logic [31:0] rd_model(input logic [31:0] a, input logic [31:0] t,
                                             input int r, input logic [31:0] w);
        int pres;
        pres = (a == t) ? r + 1 : 1;
        return (pres >= LAT) ? w : (32'hBAD0_0000 | 32'(pres));
    endfunction

    always @* mem_read_data = rd_model(mem_address, trk_addr, run, mem[mem_address[9:2]]);

    // Scoreboard
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          issue;
        int          lat_min;
        int          lat_max;
    } txn_t;

    txn_t        iq[$];
    txn_t        dq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] i_last = '0;
    logic [31:0] d_last = '0;
    int          wr_cnt = 0;
    logic        mw_prev = 1'b0;
    bit          alt_mode = 0;
    logic        alt_next = 1'b0;
    bit          mon_en = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reset wipes the reference state exactly when the DUT samples rst.
    always @(posedge clk) begin
        if (rst) begin
            iq.delete();
            dq.delete();
            i_last   = '0;
            d_last   = '0;
            wr_cnt   = 0;
            alt_next = 1'b0;
        end
    end

    txn_t m_t;
    int   m_lat;

    always @(negedge clk) begin
        if (mon_en) begin
            chk(!(i_ack && d_ack), "ack_overlap", {30'd0, i_ack, d_ack}, 32'd0);
            if (mem_write) begin
                chk(!mw_prev, "mem_write_pulse", 32'(mw_prev), 32'd0);
                if (dq.size() == 0 || !dq[0].we) begin
                    chk(0, "mem_write_unexpected", mem_address, 32'd0);
                end else begin
                    chk(mem_address == dq[0].addr, "wr_addr", mem_address, dq[0].addr);
                    chk(mem_write_data == dq[0].data, "wr_data", mem_write_data, dq[0].data);
                end
                wr_cnt++;
            end
            mw_prev = mem_write;
            if (i_ack) begin
                if (iq.size() == 0) chk(0, "i_ack_spurious", 32'd1, 32'd0);
                else begin
                    m_t    = iq.pop_front();
                    m_lat  = cyc - m_t.issue;
                    i_last = m_t.data;
                    chk(m_lat >= m_t.lat_min && m_lat <= m_t.lat_max, "i_latency",
                        32'(m_lat), 32'(m_t.lat_min));
                    if (alt_mode) begin
                        chk(alt_next == 1'b0, "grant_order_i", 32'(alt_next), 32'd0);
                        alt_next = ~alt_next;
                    end
                end
            end
            if (d_ack) begin
                if (dq.size() == 0) chk(0, "d_ack_spurious", 32'd1, 32'd0);
                else begin
                    m_t   = dq.pop_front();
                    m_lat = cyc - m_t.issue;
                    if (!m_t.we) d_last = m_t.data;
                    chk(m_lat >= m_t.lat_min && m_lat <= m_t.lat_max, "d_latency",
                        32'(m_lat), 32'(m_t.lat_min));
                    chk(wr_cnt == (m_t.we ? 1 : 0), "d_write_count", 32'(wr_cnt),
                        32'(m_t.we));
                    wr_cnt = 0;
                    if (alt_mode) begin
                        chk(alt_next == 1'b1, "grant_order_d", 32'(alt_next), 32'd1);
                        alt_next = ~alt_next;
                    end
                end
            end
            chk(i_rdata == i_last, "i_rdata", i_rdata, i_last);
            chk(d_rdata == d_last, "d_rdata", d_rdata, d_last);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drivers: called at posedge+1, return at posedge+1 of the IDLE cycle
    // following DONE with req low (caller may re-raise it at once).
    task automatic i_txn(input logic [31:0] a, input bit exact);
        txn_t t;
        bit   got = 0;
        t.we = 1'b0; t.addr = a; t.data = refm[a[9:2]]; t.issue = cyc;
        t.lat_min = LAT + 1;
        t.lat_max = exact ? LAT + 1 : (LAT + 1) + LAT + 2;
        iq.push_back(t);
        i_addr = a;
        i_req  = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (i_ack) got = 1;
        end
        if (!got) chk(0, "i_ack_timeout", a, 32'd0);
        step();
        i_req = 1'b0;
    endtask

    task automatic d_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input bit exact);
        txn_t t;
        bit   got = 0;
        int   own;
        own = we ? 2 : LAT + 1;
        if (we) refm[a[9:2]] = wd;
        t.we = we; t.addr = a; t.data = we ? wd : refm[a[9:2]]; t.issue = cyc;
        t.lat_min = own;
        t.lat_max = exact ? own : own + LAT + 2;
        dq.push_back(t);
        d_we = we; d_addr = a; d_wdata = wd;
        d_req = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (d_ack) got = 1;
        end
        if (!got) chk(0, "d_ack_timeout", a, 32'd0);
        step();
        d_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_iaddr();
        return 32'($urandom_range(1, 63)) << 2;
    endfunction

    function automatic logic [31:0] rand_daddr();
        return 32'h200 + (32'($urandom_range(0, 127)) << 2);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) refm[i] = seed_word(i);
        refm[16] = 32'h2008_0005;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;

        // Reset state
        @(negedge clk);
        chk(mem_address == 32'd0, "rst_mem_address", mem_address, 32'd0);
        chk(mem_write == 1'b0, "rst_mem_write", 32'(mem_write), 32'd0);
        chk(mem_write_data == 32'd0, "rst_mem_wdata", mem_write_data, 32'd0);
        chk(!i_ack && !d_ack, "rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        step();

        // Single fetch: address appears on the bus the cycle after the request
        fork
            i_txn(32'h40, 1);
            begin
                @(negedge clk);
                chk(mem_address == 32'd0, "idle_addr_zero", mem_address, 32'd0);
                @(negedge clk);
                chk(mem_address == 32'h40, "fetch_addr", mem_address, 32'h40);
            end
        join
        chk(i_rdata == 32'h2008_0005, "fetch_word", i_rdata, 32'h2008_0005);

        // Single store, then read it back through the fetch port
        d_txn(1, 32'h100, 32'hDEAD_BEEF, 1);
        i_txn(32'h100, 1);
        chk(i_rdata == 32'hDEAD_BEEF, "store_readback", i_rdata, 32'hDEAD_BEEF);

        // Multi-cycle load
        d_txn(0, 32'h200, 32'd0, 1);

        // Reset during the second ACCESS cycle of a read
        d_we = 1'b0; d_addr = 32'h204; d_req = 1'b1;
        step();
        step();
        rst = 1'b1;
        d_req = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk(mem_address == 32'd0, "abort_addr", mem_address, 32'd0);
        chk(!d_ack, "abort_no_ack", 32'(d_ack), 32'd0);
        repeat (4) @(negedge clk);
        step();

        // Continuous contention straight after that reset: I,D,I,D...
        alt_mode = 1;
        fork
            repeat (4) i_txn(rand_iaddr(), 0);
            repeat (4) d_txn(1'($urandom_range(0, 1)), rand_daddr(), $urandom, 0);
        join
        alt_mode = 0;
        step();

        // Fresh load after the abort
        d_txn(0, 32'h204, 32'd0, 1);

        // Random single-port traffic: exact latencies
        repeat (20) begin
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 1) == 1) i_txn(rand_iaddr(), 1);
            else d_txn(1'($urandom_range(0, 1)), rand_daddr(), $urandom, 1);
        end

        // Random concurrent traffic: bounded waits
        fork
            repeat (15) begin
                repeat ($urandom_range(0, 3)) step();
                i_txn(rand_iaddr(), 0);
            end
            repeat (15) begin
                repeat ($urandom_range(0, 3)) step();
                d_txn(1'($urandom_range(0, 1)), rand_daddr(), $urandom, 0);
            end
        join

        repeat (4) @(negedge clk);
        chk(iq.size() == 0, "iq_drained", 32'(iq.size()), 32'd0);
        chk(dq.size() == 0, "dq_drained", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
